// File: rtl/fp_pkg.sv
// Shared FPU types and constants: operation/modifier encodings, exception
// flags, and the encodings used by the non-computational unit.
package fp_pkg;

  // Default single-precision format
  localparam int unsigned FpExpWidth = 8;
  localparam int unsigned FpManWidth = 23;

  // Width of the classify one-hot mask
  localparam int unsigned CLASS_WIDTH = 10;

  typedef enum logic [3:0] {
    FMADD    = 4'd0,
    FNMSUB   = 4'd1,
    ADD      = 4'd2,
    MUL      = 4'd3,
    DIV      = 4'd4,
    SQRT     = 4'd5,
    SGNJ     = 4'd6,
    MINMAX   = 4'd7,
    CMP      = 4'd8,
    CLASSIFY = 4'd9,
    F2F      = 4'd10,
    F2I      = 4'd11,
    I2F      = 4'd12,
    CPKAB    = 4'd13,
    CPKCD    = 4'd14
  } fpnew_op_e;

  // Sign-injection variants carried on op_mod
  typedef enum logic [1:0] {
    OPMOD_SGNJ  = 2'd0,
    OPMOD_SGNJN = 2'd1,
    OPMOD_SGNJX = 2'd2
  } fpnew_op_mod_e;

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100
  } roundmode_e;

  // Min/max selection on op_mod
  typedef enum logic [1:0] {
    MM_MIN = 2'd0,
    MM_MAX = 2'd1
  } fpnew_minmax_e;

  // Compare selection reuses the rounding-mode field: RNE/RTZ/RDN
  typedef enum logic [2:0] {
    CMP_FLE = 3'b000,
    CMP_FLT = 3'b001,
    CMP_FEQ = 3'b010
  } fpnew_cmp_e;

  // Bit positions inside the classify mask
  typedef enum logic [3:0] {
    CLS_NEG_INF  = 4'd0,
    CLS_NEG_NORM = 4'd1,
    CLS_NEG_SUB  = 4'd2,
    CLS_NEG_ZERO = 4'd3,
    CLS_POS_ZERO = 4'd4,
    CLS_POS_SUB  = 4'd5,
    CLS_POS_NORM = 4'd6,
    CLS_POS_INF  = 4'd7,
    CLS_SNAN     = 4'd8,
    CLS_QNAN     = 4'd9
  } fp_class_e;

  typedef struct packed {
    logic NV;
    logic DZ;
    logic OF;
    logic UF;
    logic NX;
  } fpnew_exc_flags_t;

endpackage

// File: rtl/fp_operand_class.sv
// Combinational per-operand decode into IEEE-754 value classes.
module fp_operand_class #(
  parameter int unsigned EXP_WIDTH = 8,
  parameter int unsigned MAN_WIDTH = 23
) (
  input  logic [EXP_WIDTH+MAN_WIDTH:0] operand_i,
  output logic                         sign_o,
  output logic                         is_zero_o,
  output logic                         is_sub_o,
  output logic                         is_norm_o,
  output logic                         is_inf_o,
  output logic                         is_snan_o,
  output logic                         is_qnan_o
);

  logic [EXP_WIDTH-1:0] exp_s;
  logic [MAN_WIDTH-1:0] man_s;
  logic                 exp_zero_s;
  logic                 exp_ones_s;
  logic                 man_zero_s;

  assign sign_o     = operand_i[EXP_WIDTH+MAN_WIDTH];
  assign exp_s      = operand_i[EXP_WIDTH+MAN_WIDTH-1:MAN_WIDTH];
  assign man_s      = operand_i[MAN_WIDTH-1:0];
  assign exp_zero_s = (exp_s == '0);
  assign exp_ones_s = (exp_s == '1);
  assign man_zero_s = (man_s == '0);

  assign is_zero_o = exp_zero_s & man_zero_s;
  assign is_sub_o  = exp_zero_s & ~man_zero_s;
  assign is_norm_o = ~exp_zero_s & ~exp_ones_s;
  assign is_inf_o  = exp_ones_s & man_zero_s;
  // A NaN is signalling when the quiet bit (mantissa MSB) is clear
  assign is_snan_o = exp_ones_s & ~man_zero_s & ~man_s[MAN_WIDTH-1];
  assign is_qnan_o = exp_ones_s & man_s[MAN_WIDTH-1];

endmodule

// File: rtl/fp_noncomp_unit.sv
// FP non-computational unit: sign injection, min/max, compare and classify.
// All arithmetic happens combinationally at the input; the NUM_PIPE stages
// behind it only carry {result, status, tag} with an elastic handshake.
module fp_noncomp_unit
  import fp_pkg::*;
#(
  parameter int unsigned EXP_WIDTH = fp_pkg::FpExpWidth,
  parameter int unsigned MAN_WIDTH = fp_pkg::FpManWidth,
  parameter int unsigned NUM_PIPE  = 2,
  parameter int unsigned TAG_WIDTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [EXP_WIDTH+MAN_WIDTH:0] operand_a_i,
  input  logic [EXP_WIDTH+MAN_WIDTH:0] operand_b_i,
  input  logic [3:0]                   op_i,
  input  logic [1:0]                   op_mod_i,
  input  logic [2:0]                   rnd_mode_i,
  input  logic [TAG_WIDTH-1:0]         tag_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [EXP_WIDTH+MAN_WIDTH:0] result_o,
  output logic [4:0]                   status_o,
  output logic [TAG_WIDTH-1:0]         tag_o,
  output logic                         busy_o
);

  localparam int unsigned W  = 1 + EXP_WIDTH + MAN_WIDTH;
  localparam int unsigned DW = W + 5 + TAG_WIDTH;
  localparam logic [W-1:0] CANON_NAN = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(MAN_WIDTH-1){1'b0}}};

  logic a_sign_s, a_zero_s, a_sub_s, a_norm_s, a_inf_s, a_snan_s, a_qnan_s;
  logic b_sign_s, b_zero_s, b_sub_s, b_norm_s, b_inf_s, b_snan_s, b_qnan_s;

  fp_operand_class #(.EXP_WIDTH(EXP_WIDTH), .MAN_WIDTH(MAN_WIDTH)) u_class_a (
    .operand_i(operand_a_i), .sign_o(a_sign_s), .is_zero_o(a_zero_s), .is_sub_o(a_sub_s),
    .is_norm_o(a_norm_s), .is_inf_o(a_inf_s), .is_snan_o(a_snan_s), .is_qnan_o(a_qnan_s)
  );

  fp_operand_class #(.EXP_WIDTH(EXP_WIDTH), .MAN_WIDTH(MAN_WIDTH)) u_class_b (
    .operand_i(operand_b_i), .sign_o(b_sign_s), .is_zero_o(b_zero_s), .is_sub_o(b_sub_s),
    .is_norm_o(b_norm_s), .is_inf_o(b_inf_s), .is_snan_o(b_snan_s), .is_qnan_o(b_qnan_s)
  );

  // Classify only ever looks at operand A, so B's finite/inf flags go unused
  logic unused_b_class_s;
  assign unused_b_class_s = b_sub_s ^ b_norm_s ^ b_inf_s;

  logic a_nan_s, b_nan_s, any_snan_s, any_nan_s, both_zero_s;
  logic mag_lt_s, mag_eq_s, lt_ord_s, lt_cmp_s, eq_cmp_s;

  assign a_nan_s     = a_snan_s | a_qnan_s;
  assign b_nan_s     = b_snan_s | b_qnan_s;
  assign any_snan_s  = a_snan_s | b_snan_s;
  assign any_nan_s   = a_nan_s | b_nan_s;
  assign both_zero_s = a_zero_s & b_zero_s;
  assign mag_lt_s    = (operand_a_i[W-2:0] <  operand_b_i[W-2:0]);
  assign mag_eq_s    = (operand_a_i[W-2:0] == operand_b_i[W-2:0]);

  // Total order on non-NaN values with -0 below +0 (min/max ordering)
  always_comb begin
    if (a_sign_s != b_sign_s) begin
      lt_ord_s = a_sign_s;
    end else if (a_sign_s) begin
      lt_ord_s = ~mag_lt_s & ~mag_eq_s;
    end else begin
      lt_ord_s = mag_lt_s;
    end
  end

  // Compare treats +0 and -0 as equal
  assign lt_cmp_s = lt_ord_s & ~both_zero_s;
  assign eq_cmp_s = (mag_eq_s & (a_sign_s == b_sign_s)) | both_zero_s;

  fpnew_op_e                op_s;
  logic [W-1:0]             res_s;
  fpnew_exc_flags_t         status_s;
  logic                     sgnj_sign_s;
  logic                     cmp_bit_s;
  logic [CLASS_WIDTH-1:0]   class_mask_s;

  assign op_s = fpnew_op_e'(op_i);

  // Classify mask of operand A
  always_comb begin
    class_mask_s = '0;
    class_mask_s[CLS_NEG_INF]  = a_inf_s  &  a_sign_s;
    class_mask_s[CLS_NEG_NORM] = a_norm_s &  a_sign_s;
    class_mask_s[CLS_NEG_SUB]  = a_sub_s  &  a_sign_s;
    class_mask_s[CLS_NEG_ZERO] = a_zero_s &  a_sign_s;
    class_mask_s[CLS_POS_ZERO] = a_zero_s & ~a_sign_s;
    class_mask_s[CLS_POS_SUB]  = a_sub_s  & ~a_sign_s;
    class_mask_s[CLS_POS_NORM] = a_norm_s & ~a_sign_s;
    class_mask_s[CLS_POS_INF]  = a_inf_s  & ~a_sign_s;
    class_mask_s[CLS_SNAN]     = a_snan_s;
    class_mask_s[CLS_QNAN]     = a_qnan_s;
  end

  // Operation datapath: result and exception flags
  always_comb begin
    res_s       = '0;
    status_s    = '0;
    sgnj_sign_s = operand_b_i[W-1];
    cmp_bit_s   = 1'b0;
    case (op_s)
      SGNJ: begin
        case (fpnew_op_mod_e'(op_mod_i))
          OPMOD_SGNJN: sgnj_sign_s = ~operand_b_i[W-1];
          OPMOD_SGNJX: sgnj_sign_s = operand_a_i[W-1] ^ operand_b_i[W-1];
          default:     sgnj_sign_s = operand_b_i[W-1];
        endcase
        res_s = {sgnj_sign_s, operand_a_i[W-2:0]};
      end
      MINMAX: begin
        status_s.NV = any_snan_s;
        if (a_nan_s && b_nan_s) begin
          res_s = CANON_NAN;
        end else if (a_nan_s) begin
          res_s = operand_b_i;
        end else if (b_nan_s) begin
          res_s = operand_a_i;
        end else if (fpnew_minmax_e'(op_mod_i) == MM_MAX) begin
          res_s = lt_ord_s ? operand_b_i : operand_a_i;
        end else begin
          res_s = lt_ord_s ? operand_a_i : operand_b_i;
        end
      end
      CMP: begin
        case (fpnew_cmp_e'(rnd_mode_i))
          CMP_FEQ: begin
            status_s.NV = any_snan_s;
            cmp_bit_s   = ~any_nan_s & eq_cmp_s;
          end
          CMP_FLT: begin
            status_s.NV = any_nan_s;
            cmp_bit_s   = ~any_nan_s & lt_cmp_s;
          end
          CMP_FLE: begin
            status_s.NV = any_nan_s;
            cmp_bit_s   = ~any_nan_s & (lt_cmp_s | eq_cmp_s);
          end
          default: begin
            status_s.NV = 1'b1;
            cmp_bit_s   = 1'b0;
          end
        endcase
        res_s = {{(W-1){1'b0}}, cmp_bit_s};
      end
      CLASSIFY: begin
        res_s = {{(W-CLASS_WIDTH){1'b0}}, class_mask_s};
      end
      default: begin
        status_s.NV = 1'b1;
      end
    endcase
  end

  logic [DW-1:0] in_data_s;
  assign in_data_s = {res_s, status_s, tag_i};

  if (NUM_PIPE == 0) begin : g_comb
    assign in_ready_o  = out_ready_i;
    assign out_valid_o = in_valid_i & ~flush_i;
    assign {result_o, status_o, tag_o} = out_valid_o ? in_data_s : '0;
    assign busy_o      = 1'b0;
  end else begin : g_pipe
    logic [NUM_PIPE-1:0] busy_vec_s;

    for (genvar k = 0; k < NUM_PIPE; k++) begin : g_stage
      logic          valid_q, valid_d;
      logic [DW-1:0] data_q, data_d;
      logic          up_valid_s;
      logic [DW-1:0] up_data_s;
      logic          down_ready_s;
      logic          ready_s;

      if (k == 0) begin : g_first
        assign up_valid_s = in_valid_i;
        assign up_data_s  = in_data_s;
      end else begin : g_mid
        assign up_valid_s = g_stage[k-1].valid_q;
        assign up_data_s  = g_stage[k-1].data_q;
      end

      if (k == NUM_PIPE - 1) begin : g_last
        assign down_ready_s = out_ready_i;
      end else begin : g_inner
        assign down_ready_s = g_stage[k+1].ready_s;
      end

      assign ready_s       = ~valid_q | down_ready_s;
      assign busy_vec_s[k] = valid_q;

      // Stage load/hold; flush drops everything including the incoming op
      always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush_i) begin
          valid_d = 1'b0;
        end else if (ready_s) begin
          valid_d = up_valid_s;
          if (up_valid_s) begin
            data_d = up_data_s;
          end else begin
            data_d = data_q;
          end
        end else begin
          valid_d = valid_q;
        end
      end

      // Stage register
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_q <= 1'b0;
          data_q  <= '0;
        end else begin
          valid_q <= valid_d;
          data_q  <= data_d;
        end
      end
    end

    assign in_ready_o  = g_stage[0].ready_s;
    assign out_valid_o = g_stage[NUM_PIPE-1].valid_q;
    assign {result_o, status_o, tag_o} = g_stage[NUM_PIPE-1].data_q;
    assign busy_o      = |busy_vec_s;
  end

endmodule

// File: tb/tb_fp_noncomp_unit.sv
// Directed bench for fp_noncomp_unit: single-precision two-stage instance
// plus a half-precision combinational instance.
module tb_fp_noncomp_unit;

  localparam logic [3:0] OP_ADD = 4'd2, OP_SGNJ = 4'd6, OP_MINMAX = 4'd7;
  localparam logic [3:0] OP_CMP = 4'd8, OP_CLASS = 4'd9;
  localparam logic [4:0] NV = 5'h10, OK = 5'h00;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid, in_ready;
  logic [31:0] op_a, op_b;
  logic [3:0]  op;
  logic [1:0]  op_mod;
  logic [2:0]  rnd;
  logic [3:0]  tag_in, tag_out;
  logic        out_valid, out_ready;
  logic [31:0] result;
  logic [4:0]  status;
  logic        busy;

  logic        h_valid, h_ready, h_out_valid, h_busy;
  logic [15:0] h_a, h_b, h_result;
  logic [3:0]  h_op, h_tag_out;
  logic [1:0]  h_mod;
  logic [2:0]  h_rnd;
  logic [4:0]  h_status;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fp_noncomp_unit u_dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .operand_a_i(op_a), .operand_b_i(op_b), .op_i(op), .op_mod_i(op_mod), .rnd_mode_i(rnd),
    .tag_i(tag_in), .out_valid_o(out_valid), .out_ready_i(out_ready), .result_o(result),
    .status_o(status), .tag_o(tag_out), .busy_o(busy)
  );

  fp_noncomp_unit #(.EXP_WIDTH(5), .MAN_WIDTH(10), .NUM_PIPE(0), .TAG_WIDTH(4)) u_dut_h (
    .clk(clk), .rst_n(rst_n), .flush_i(1'b0), .in_valid_i(h_valid), .in_ready_o(h_ready),
    .operand_a_i(h_a), .operand_b_i(h_b), .op_i(h_op), .op_mod_i(h_mod), .rnd_mode_i(h_rnd),
    .tag_i(4'd0), .out_valid_o(h_out_valid), .out_ready_i(1'b1), .result_o(h_result),
    .status_o(h_status), .tag_o(h_tag_out), .busy_o(h_busy)
  );

  task automatic check_val(input string name, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, obs, exp_v);
    end
  endtask

  // One operation through the 2-stage pipe with no backpressure
  task automatic run_op(input string name, input logic [3:0] o, input logic [1:0] m,
                        input logic [2:0] r, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] t, input logic [31:0] exp_res, input logic [4:0] exp_st);
    @(negedge clk);
    op = o; op_mod = m; rnd = r; op_a = a; op_b = b; tag_in = t; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check_val({name, "/early"}, {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check_val({name, "/valid"}, {31'd0, out_valid}, 32'd1);
    check_val({name, "/res"}, result, exp_res);
    check_val({name, "/st"}, {27'd0, status}, {27'd0, exp_st});
    check_val({name, "/tag"}, {28'd0, tag_out}, {28'd0, t});
  endtask

  // Half-precision combinational instance: result visible in the same cycle
  task automatic run_h(input string name, input logic [3:0] o, input logic [1:0] m,
                       input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] exp_res, input logic [4:0] exp_st);
    h_op = o; h_mod = m; h_a = a; h_b = b; h_valid = 1'b1;
    #1;
    check_val({name, "/valid"}, {31'd0, h_out_valid}, 32'd1);
    check_val({name, "/res"}, {16'd0, h_result}, {16'd0, exp_res});
    check_val({name, "/st"}, {27'd0, h_status}, {27'd0, exp_st});
    h_valid = 1'b0;
    #1;
  endtask

  int          sent, got, seen;
  logic        acc, deliver;
  logic [3:0]  got_tag [8];
  logic [31:0] got_res [8];

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op_a = 32'd0; op_b = 32'd0; op = 4'd0; op_mod = 2'd0; rnd = 3'd0; tag_in = 4'd0;
    h_valid = 1'b0; h_a = 16'd0; h_b = 16'd0; h_op = 4'd0; h_mod = 2'd0; h_rnd = 3'd0;

    // Reset state
    #12;
    check_val("rst/out_valid", {31'd0, out_valid}, 32'd0);
    check_val("rst/result", result, 32'd0);
    check_val("rst/status", {27'd0, status}, 32'd0);
    check_val("rst/tag", {28'd0, tag_out}, 32'd0);
    check_val("rst/busy", {31'd0, busy}, 32'd0);
    check_val("rst/in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Classify
    run_op("cls_ninf",  OP_CLASS, 2'd0, 3'd0, 32'hFF800000, 32'd0, 4'd1, 32'h001, OK);
    run_op("cls_snan",  OP_CLASS, 2'd0, 3'd0, 32'h7F800001, 32'd0, 4'd2, 32'h100, OK);
    run_op("cls_psub",  OP_CLASS, 2'd0, 3'd0, 32'h00000001, 32'd0, 4'd3, 32'h020, OK);
    run_op("cls_pnorm", OP_CLASS, 2'd0, 3'd0, 32'h3F800000, 32'd0, 4'd4, 32'h040, OK);
    run_op("cls_nzero", OP_CLASS, 2'd0, 3'd0, 32'h80000000, 32'd0, 4'd5, 32'h008, OK);
    run_op("cls_qnan",  OP_CLASS, 2'd0, 3'd0, 32'hFFC00000, 32'd0, 4'd6, 32'h200, OK);

    // Min/max
    run_op("min_zeros", OP_MINMAX, 2'd0, 3'd0, 32'h80000000, 32'h00000000, 4'd7, 32'h80000000, OK);
    run_op("max_snan",  OP_MINMAX, 2'd1, 3'd0, 32'h7F800001, 32'h3F800000, 4'd8, 32'h3F800000, NV);
    run_op("min_2qnan", OP_MINMAX, 2'd0, 3'd0, 32'h7FC00000, 32'hFFC00001, 4'd9, 32'h7FC00000, OK);
    run_op("max_sign",  OP_MINMAX, 2'd1, 3'd0, 32'hBF800000, 32'h3F800000, 4'd10, 32'h3F800000, OK);
    run_op("min_neg",   OP_MINMAX, 2'd0, 3'd0, 32'hC0000000, 32'hBF800000, 4'd11, 32'hC0000000, OK);

    // Compare
    run_op("feq_qnan",  OP_CMP, 2'd0, 3'd2, 32'h7FC00000, 32'h7FC00000, 4'd12, 32'd0, OK);
    run_op("flt_qnan",  OP_CMP, 2'd0, 3'd1, 32'h7FC00000, 32'h7FC00000, 4'd13, 32'd0, NV);
    run_op("fle_zeros", OP_CMP, 2'd0, 3'd0, 32'h80000000, 32'h00000000, 4'd14, 32'd1, OK);
    run_op("flt_m1p1",  OP_CMP, 2'd0, 3'd1, 32'hBF800000, 32'h3F800000, 4'd15, 32'd1, OK);
    run_op("flt_zeros", OP_CMP, 2'd0, 3'd1, 32'h80000000, 32'h00000000, 4'd0, 32'd0, OK);
    run_op("feq_zeros", OP_CMP, 2'd0, 3'd2, 32'h80000000, 32'h00000000, 4'd1, 32'd1, OK);
    run_op("feq_snan",  OP_CMP, 2'd0, 3'd2, 32'h7F800001, 32'h3F800000, 4'd2, 32'd0, NV);
    run_op("fle_p1m1",  OP_CMP, 2'd0, 3'd0, 32'h3F800000, 32'hBF800000, 4'd3, 32'd0, OK);
    run_op("cmp_badrm", OP_CMP, 2'd0, 3'd3, 32'h3F800000, 32'h3F800000, 4'd4, 32'd0, NV);

    // Sign injection and unsupported op
    run_op("sgnjx",     OP_SGNJ, 2'd2, 3'd0, 32'hBF800000, 32'h80000000, 4'd5, 32'h3F800000, OK);
    run_op("sgnjn",     OP_SGNJ, 2'd1, 3'd0, 32'h7F800001, 32'h00000000, 4'd6, 32'hFF800001, OK);
    run_op("sgnj",      OP_SGNJ, 2'd0, 3'd0, 32'h3F800000, 32'h80000000, 4'd7, 32'hBF800000, OK);
    run_op("sgnj_mod3", OP_SGNJ, 2'd3, 3'd0, 32'hC0000000, 32'h00000000, 4'd8, 32'h40000000, OK);
    run_op("bad_op",    OP_ADD,  2'd0, 3'd0, 32'h3F800000, 32'h3F800000, 4'd9, 32'd0, NV);

    // Half precision, combinational path
    run_h("h_cls_ninf", OP_CLASS, 2'd0, 16'hFC00, 16'h0000, 16'h0001, OK);
    run_h("h_max_nan",  OP_MINMAX, 2'd1, 16'h7C01, 16'h7E00, 16'h7E00, NV);
    run_h("h_min",      OP_MINMAX, 2'd0, 16'h3C00, 16'hBC00, 16'hBC00, OK);

    // Backpressure: 6 stalled cycles, then drain 4 ops tagged 0..3
    sent = 0; got = 0;
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      if (cyc == 6) out_ready = 1'b1;
      if (sent < 4) begin
        op = OP_SGNJ; op_mod = 2'd0; op_a = 32'h80000100 + sent; op_b = 32'd0;
        tag_in = sent[3:0]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (cyc == 2 || cyc == 5) begin
        check_val("bp/sent_at_stall", sent, 32'd2);
        check_val("bp/in_ready_low", {31'd0, in_ready}, 32'd0);
      end
      acc     = in_valid & in_ready;
      deliver = out_valid & out_ready;
      if (deliver) begin
        if (got < 8) begin
          got_tag[got] = tag_out;
          got_res[got] = result;
        end
        got++;
      end
      @(posedge clk);
      if (acc) sent++;
    end
    check_val("bp/count", got, 32'd4);
    seen = (got < 4) ? got : 4;
    for (int i = 0; i < seen; i++) begin
      check_val($sformatf("bp/tag%0d", i), {28'd0, got_tag[i]}, i);
      check_val($sformatf("bp/res%0d", i), got_res[i], 32'h00000100 + i);
    end

    // Flush with two ops in flight; the op offered alongside flush is dropped
    out_ready = 1'b0;
    @(negedge clk);
    op = OP_CLASS; op_a = 32'h3F800000; tag_in = 4'd1; in_valid = 1'b1;
    @(negedge clk);
    tag_in = 4'd2;
    @(negedge clk);
    tag_in = 4'd3; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    check_val("flush/out_valid", {31'd0, out_valid}, 32'd0);
    check_val("flush/busy", {31'd0, busy}, 32'd0);
    check_val("flush/in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check_val("flush/no_leak", seen, 32'd0);

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    @(negedge clk);
    op = OP_CLASS; op_a = 32'hFF800000; tag_in = 4'd5; in_valid = 1'b1;
    @(negedge clk);
    tag_in = 4'd6;
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_val("arst/out_valid", {31'd0, out_valid}, 32'd0);
    check_val("arst/busy", {31'd0, busy}, 32'd0);
    check_val("arst/in_ready", {31'd0, in_ready}, 32'd1);
    check_val("arst/result", result, 32'd0);
    check_val("arst/tag", {28'd0, tag_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check_val("arst/no_leak", seen, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fp_noncomp_unit.md
Name: fp_noncomp_unit

Overview:
- Pipelined, parametrised FP non-computational unit: sign injection (FP_SGNJ), min/max (FP_MINMAX), compare (FP_CMP) and classify (FP_CLASSIFY).
- Format-generic via exponent/mantissa width parameters; defaults to the fp_pkg single-precision constants.
- Sits beside the FMA/divider in the FPU datapath with an elastic valid/ready handshake, a transaction tag and flush.
- Produces a result and fpnew_exc_flags_t status per operation.

Parameters:
- EXP_WIDTH, fp_pkg::FpExpWidth (8): exponent bits.
- MAN_WIDTH, fp_pkg::FpManWidth (23): mantissa bits. FP width W = 1+EXP_WIDTH+MAN_WIDTH, and W must be >= 10.
- NUM_PIPE, 2: pipeline register stages, 0..4. 0 gives a combinational path.
- TAG_WIDTH, 4: width of the opaque tag carried alongside each operation.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush_i  in  1  kill all in-flight operations
- in_valid_i  in  1  operation valid
- in_ready_o  out  1  unit can accept an operation
- operand_a_i  in  W  operand A
- operand_b_i  in  W  operand B
- op_i  in  4  fpnew_op_e
- op_mod_i  in  2  SGNJ variant (fpnew_op_mod_e); MINMAX: 0=min, 1=max
- rnd_mode_i  in  3  CMP select: RNE=FLE, RTZ=FLT, RDN=FEQ
- tag_i  in  TAG_WIDTH  transaction tag
- out_valid_o  out  1  result valid
- out_ready_i  in  1  consumer accepts the result
- result_o  out  W  result
- status_o  out  5  fpnew_exc_flags_t {NV,DZ,OF,UF,NX}
- tag_o  out  TAG_WIDTH  tag of the result
- busy_o  out  1  any stage holds a valid operation

Behaviour:
- Reset: all stage valids 0; out_valid_o=0, result_o=0, status_o=0, tag_o=0, busy_o=0; in_ready_o=1.
- Handshake and ordering:
  - Transfer on valid&&ready. Stage k ready = !valid_k || ready_(k+1); the last stage's ready is out_ready_i.
  - Result of an accepted operation appears NUM_PIPE cycles later when there is no backpressure.
  - Strictly in order; full throughput of 1 op per cycle.
  - Held outputs stay stable while out_valid_o && !out_ready_i.
- All computation is in stage 0 (combinational). Later stages only register the result.
- Operand decode (fp_operand_class):
  - zero: exp=0, man=0.
  - subnormal: exp=0, man!=0.
  - inf: exp all-ones, man=0.
  - NaN: exp all-ones, man!=0. sNaN when man MSB=0, else qNaN.
  - Canonical NaN: sign 0, exp all-ones, man MSB 1, rest 0.
- SGNJ: result = {s, a[W-2:0]}. s = b sign (SGNJ), ~b sign (SGNJN), a^b sign (SGNJX). op_mod 3 behaves as SGNJ. Never raises flags.
- MINMAX:
  - Both NaN -> canonical NaN. One NaN -> the other operand.
  - -0 is ordered below +0.
  - NV=1 if either operand is sNaN.
- CMP: result is 0/1 zero-extended.
  - Any NaN operand -> result 0.
  - FEQ raises NV only for sNaN. FLT/FLE raise NV for any NaN.
  - +0 == -0.
  - Other rnd_mode values -> result 0, NV=1.
- Magnitude compare: unsigned compare of {exp,man}, then sign-corrected.
- CLASSIFY: 10-bit one-hot mask, zero-extended; never raises flags.
  - bit0 -inf, bit1 -normal, bit2 -subnormal, bit3 -0, bit4 +0.
  - bit5 +subnormal, bit6 +normal, bit7 +inf, bit8 sNaN, bit9 qNaN.
- Unsupported op_i: result 0, NV=1.
- DZ, OF, UF, NX are always 0.
- Flush: all valids clear on the next edge, so out_valid_o=0 the next cycle. An in_valid_i in the same cycle as flush_i is dropped.
- Asynchronous reset mid-operation discards all in-flight operations.

Decomposition:
- fp_pkg additions:
  - fp_class_e: classify bit positions.
  - fpnew_minmax_e: MM_MIN/MM_MAX.
  - fpnew_cmp_e: CMP_FLE/CMP_FLT/CMP_FEQ, aliased to the rnd_mode encodings.
  - CLASS_WIDTH=10.
- Sub-module fp_operand_class, parametrised by EXP_WIDTH/MAN_WIDTH: combinational per-operand flags is_zero/is_sub/is_norm/is_inf/is_snan/is_qnan/sign. Instantiated twice.

Test Plan:
- CLASSIFY 0xFF800000 -> 0x001; 0x7F800001 -> 0x100; 0x00000001 -> 0x020; status 0.
- MINMAX:
  - min(0x80000000, 0x00000000) -> 0x80000000.
  - max(0x7F800001, 0x3F800000) -> 0x3F800000, NV=1.
  - min(0x7FC00000, 0xFFC00001) -> 0x7FC00000, NV=0.
- CMP:
  - FEQ(0x7FC00000, 0x7FC00000) -> 0, NV=0.
  - FLT on the same operands -> 0, NV=1.
  - FLE(0x80000000, 0x00000000) -> 1.
  - FLT(0xBF800000, 0x3F800000) -> 1.
- SGNJX(0xBF800000, 0x80000000) -> 0x3F800000. SGNJN(0x7F800001, 0x00000000) -> 0xFF800001, NV=0.
- NUM_PIPE=2, out_ready_i low for 6 cycles, 4 back-to-back ops with tags 0..3:
  - in_ready_o drops after 2 accepts.
  - After release, results emerge in order with tags 0,1,2,3: no loss, no duplicates.
- Flush and reset:
  - flush_i with 2 ops in flight -> next cycle out_valid_o=0, busy_o=0, in_ready_o=1.
  - rst_n pulse mid-stream gives the same result, asynchronously.
- EXP_WIDTH=5, MAN_WIDTH=10, NUM_PIPE=0:
  - CLASSIFY 0xFC00 -> 0x001 in the same cycle.
  - max(0x7C01, 0x7E00) -> 0x7E00, NV=1.
